// File: rtl/keyed_lut_writer.sv
// Runtime-writable key->data lookup table with handshake write/lookup ports and a flush sequencer.
// Optional hit/miss counters are enabled by defining KEYED_LUT_STATS_EN.
module keyed_lut_writer #(
    parameter int unsigned NR_ENTRY = 4,
    parameter int unsigned KEY_LEN  = 8,
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    output logic                busy,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic                wr_del,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                lk_valid,
    output logic                lk_ready,
    input  logic [KEY_LEN-1:0]  lk_key,
    input  logic [DATA_LEN-1:0] default_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                full
`ifdef KEYED_LUT_STATS_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);
    localparam int unsigned IDX_W = $clog2(NR_ENTRY);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NR_ENTRY-1:0] valid_q, valid_d;
    logic [KEY_LEN-1:0]  key_q  [NR_ENTRY];
    logic [KEY_LEN-1:0]  key_d  [NR_ENTRY];
    logic [DATA_LEN-1:0] data_q [NR_ENTRY];
    logic [DATA_LEN-1:0] data_d [NR_ENTRY];

    logic                wr_fire, lk_fire;
    logic                lk_hit;
    logic [DATA_LEN-1:0] lk_data;
    logic                wr_hit;
    logic [IDX_W-1:0]    wr_idx;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;

    assign busy     = (state_q == StFlush);
    assign wr_ready = (state_q == StIdle) & ~flush;
    assign lk_ready = (state_q == StIdle) & ~flush & (~rsp_valid | rsp_ready);
    assign wr_fire  = wr_valid & wr_ready;
    assign lk_fire  = lk_valid & lk_ready;
    assign full     = &valid_q;

    // Keys are unique among valid entries, so OR-reducing matched data is a clean mux.
    always_comb begin
        lk_hit     = 1'b0;
        lk_data    = '0;
        wr_hit     = 1'b0;
        wr_idx     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(NR_ENTRY); i++) begin
            if (valid_q[i] && key_q[i] == lk_key) begin
                lk_hit  = 1'b1;
                lk_data = lk_data | data_q[i];
            end
            if (valid_q[i] && key_q[i] == wr_key) begin
                wr_hit = 1'b1;
                wr_idx = IDX_W'(i);
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        key_d   = key_q;
        data_d  = data_q;

        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                end
            end
            StFlush: begin
                valid_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(NR_ENTRY - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wr_fire) begin
            if (wr_del) begin
                if (wr_hit) begin
                    valid_d[wr_idx] = 1'b0;
                end
            end else if (wr_hit) begin
                data_d[wr_idx] = wr_data;
            end else if (free_found) begin
                key_d[free_idx]   = wr_key;
                data_d[free_idx]  = wr_data;
                valid_d[free_idx] = 1'b1;
            end else begin
                // Table full: round-robin replacement, ptr wraps naturally at power-of-two size.
                key_d[ptr_q]  = wr_key;
                data_d[ptr_q] = wr_data;
                ptr_d         = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            valid_q <= '0;
            key_q   <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            key_q   <= key_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_data  <= '0;
        end else if (lk_fire) begin
            rsp_valid <= 1'b1;
            rsp_hit   <= lk_hit;
            rsp_data  <= lk_hit ? lk_data : default_out;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef KEYED_LUT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == StIdle && flush) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (lk_fire) begin
            if (lk_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keyed_lut_writer.sv
// Directed bench for keyed_lut_writer: a table-level model checked every cycle plus literal checks.
module tb_keyed_lut_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        wr_del = 1'b0;
    logic [7:0]  wr_key = '0;
    logic [31:0] wr_data = '0;
    logic        lk_valid = 1'b0;
    logic        lk_ready;
    logic [7:0]  lk_key = '0;
    logic [31:0] default_out = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_hit;
    logic [31:0] rsp_data;
    logic        full;
`ifdef KEYED_LUT_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    keyed_lut_writer #(.NR_ENTRY(4), .KEY_LEN(8), .DATA_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_del(wr_del),
        .wr_key(wr_key), .wr_data(wr_data),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
        .default_out(default_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_data(rsp_data), .full(full)
`ifdef KEYED_LUT_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Table model: a set of (key,data) slots, lowest-free fill, round-robin eviction when full.
    bit          m_valid [4];
    logic [7:0]  m_key   [4];
    logic [31:0] m_data  [4];
    int          m_ptr;
    bit          m_flushing;
    int          m_fcnt;
    bit          m_rv, m_rh;
    logic [31:0] m_rd;
    logic [31:0] m_hits, m_misses;

    function automatic int m_find(logic [7:0] k);
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_key[i] == k) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic bit m_full();
        return m_free() < 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_key[i] = '0; m_data[i] = '0;
        end
        m_ptr = 0; m_flushing = 0; m_fcnt = 0;
        m_rv = 0; m_rh = 0; m_rd = '0; m_hits = '0; m_misses = '0;
    endtask

    task automatic model_step();
        bit wacc, lacc;
        int li, wi, fi;
        wacc = wr_valid && !m_flushing && !flush;
        lacc = lk_valid && !m_flushing && !flush && (!m_rv || rsp_ready);
        li = m_find(lk_key);
        if (lacc) begin
            m_rv = 1;
            m_rh = (li >= 0);
            m_rd = (li >= 0) ? m_data[li] : default_out;
            if (li >= 0) m_hits = m_hits + 1; else m_misses = m_misses + 1;
        end else if (rsp_ready) begin
            m_rv = 0;
        end
        if (m_flushing) begin
            m_valid[m_fcnt] = 0;
            if (m_fcnt == 3) m_flushing = 0; else m_fcnt++;
        end else if (flush) begin
            m_flushing = 1; m_fcnt = 0; m_hits = '0; m_misses = '0;
        end
        if (wacc) begin
            wi = m_find(wr_key);
            fi = m_free();
            if (wr_del) begin
                if (wi >= 0) m_valid[wi] = 0;
            end else if (wi >= 0) begin
                m_data[wi] = wr_data;
            end else if (fi >= 0) begin
                m_valid[fi] = 1; m_key[fi] = wr_key; m_data[fi] = wr_data;
            end else begin
                m_key[m_ptr] = wr_key; m_data[m_ptr] = wr_data;
                m_ptr = (m_ptr + 1) % 4;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("busy", busy, m_flushing);
                check("full", full, m_full());
                check("wr_ready", wr_ready, !m_flushing && !flush);
                check("lk_ready", lk_ready, !m_flushing && !flush && (!m_rv || rsp_ready));
                check("rsp_valid", rsp_valid, m_rv);
                check("rsp_hit", rsp_hit, m_rh);
                check("rsp_data", rsp_data, m_rd);
`ifdef KEYED_LUT_STATS_EN
                check("hit_cnt", hit_cnt, m_hits);
                check("miss_cnt", miss_cnt, m_misses);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_wr(bit del, logic [7:0] k, logic [31:0] d);
        wr_valid = 1'b1; wr_del = del; wr_key = k; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic lk_expect(string nm, logic [7:0] k, logic [31:0] dflt, bit hit, logic [31:0] d);
        lk_valid = 1'b1; lk_key = k; default_out = dflt;
        step();
        lk_valid = 1'b0;
        check({nm, "_valid"}, rsp_valid, 1'b1);
        check({nm, "_hit"}, rsp_hit, hit);
        check({nm, "_data"}, rsp_data, d);
    endtask

    initial begin
        do_reset();
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);

        lk_expect("miss_empty", 8'h12, 32'hDEAD, 1'b0, 32'hDEAD);
        check("empty_full", full, 1'b0);
        do_wr(1'b0, 8'h12, 32'h1111);
        lk_expect("ins", 8'h12, 32'hDEAD, 1'b1, 32'h1111);
        do_wr(1'b0, 8'h12, 32'h2222);
        lk_expect("upd", 8'h12, 32'hDEAD, 1'b1, 32'h2222);
        do_wr(1'b0, 8'h20, 32'h20);
        do_wr(1'b0, 8'h21, 32'h21);
        check("no_dup_full", full, 1'b0);
        do_wr(1'b0, 8'h22, 32'h22);
        check("four_full", full, 1'b1);

        // Replacement order and pointer wrap.
        do_reset();
        for (int k = 1; k <= 4; k++) do_wr(1'b0, 8'(k), 32'h100 + 32'(k));
        check("fill_full", full, 1'b1);
        do_wr(1'b0, 8'h05, 32'h105);
        lk_expect("evict1", 8'h01, 32'hBEEF, 1'b0, 32'hBEEF);
        lk_expect("new5", 8'h05, 32'hBEEF, 1'b1, 32'h105);
        do_wr(1'b0, 8'h06, 32'h106);
        lk_expect("evict2", 8'h02, 32'hBEEF, 1'b0, 32'hBEEF);
        lk_expect("new6", 8'h06, 32'hBEEF, 1'b1, 32'h106);
        do_wr(1'b0, 8'h07, 32'h107);
        do_wr(1'b0, 8'h08, 32'h108);
        do_wr(1'b0, 8'h09, 32'h109);
        lk_expect("wrap5", 8'h05, 32'hBEEF, 1'b0, 32'hBEEF);
        lk_expect("new9", 8'h09, 32'hBEEF, 1'b1, 32'h109);

        // Deletes; free-slot fill must not move the pointer (still 1).
        do_wr(1'b1, 8'h55, 32'h0);
        check("del_absent_full", full, 1'b1);
        do_wr(1'b1, 8'h06, 32'h0);
        check("del_full", full, 1'b0);
        do_wr(1'b0, 8'h30, 32'h130);
        check("refill_full", full, 1'b1);

        // Same-cycle insert and lookup: lookup sees the old table.
        wr_valid = 1'b1; wr_del = 1'b0; wr_key = 8'h47; wr_data = 32'hAAAA;
        lk_valid = 1'b1; lk_key = 8'h47; default_out = 32'hBEEF;
        step();
        wr_valid = 1'b0; lk_valid = 1'b0;
        check("rbw_hit", rsp_hit, 1'b0);
        check("rbw_data", rsp_data, 32'hBEEF);
        lk_expect("rbw_next", 8'h47, 32'hBEEF, 1'b1, 32'hAAAA);
        lk_expect("evict30", 8'h30, 32'hBEEF, 1'b0, 32'hBEEF);

        // Backpressure then back-to-back responses.
        lk_valid = 1'b1; lk_key = 8'h47; default_out = 32'h0;
        step();
        rsp_ready = 1'b0; lk_key = 8'h09;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_lk_ready", lk_ready, 1'b0);
            check("bp_data", rsp_data, 32'hAAAA);
            check("bp_valid", rsp_valid, 1'b1);
        end
        rsp_ready = 1'b1;
        #1 check("bp_release", lk_ready, 1'b1);
        step();
        check("b2b_9", rsp_data, 32'h109);
        lk_key = 8'h08;
        step();
        check("b2b_8", rsp_data, 32'h108);
        lk_key = 8'h07;
        step();
        check("b2b_7", rsp_data, 32'h107);
        lk_valid = 1'b0;
        step();
        check("b2b_drain", rsp_valid, 1'b0);

        // Flush with a pending response held across it.
        lk_valid = 1'b1; lk_key = 8'h08; rsp_ready = 1'b0;
        step();
        lk_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wr_valid = 1'b1; wr_key = 8'h99; lk_valid = 1'b1; lk_key = 8'h09;
        for (int i = 0; i < 4; i++) begin
            check("fl_busy", busy, 1'b1);
            check("fl_wr_ready", wr_ready, 1'b0);
            check("fl_lk_ready", lk_ready, 1'b0);
            flush = (i == 1);
            step();
        end
        flush = 1'b0; wr_valid = 1'b0; lk_valid = 1'b0;
        check("fl_done", busy, 1'b0);
        check("fl_full", full, 1'b0);
        check("fl_pending", rsp_data, 32'h108);
        rsp_ready = 1'b1;
        lk_expect("post_fl9", 8'h09, 32'hF00D, 1'b0, 32'hF00D);
        lk_expect("post_fl47", 8'h47, 32'hF00D, 1'b0, 32'hF00D);

        // Reset in the middle of a flush.
        do_wr(1'b0, 8'h01, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("mid_fl_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rsp", rsp_valid, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        check("after_rst_busy", busy, 1'b0);
        lk_expect("after_rst", 8'h01, 32'h5, 1'b0, 32'h5);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
